instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Produces instructions for the control decoder and datapath: holds the PC, fetches each instruction word from instruction memory over a req/ack handshake, and presents it with its opcode/funct fields split out.
- Computes the next PC from the jump/branch decision returned by the control and ALU path in the consuming cycle.
- Sits between the instruction memory and the control decoder.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; word-aligned.
- ADDR_W, 32, PC and memory address width; fixed at 32 for this design.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  memory response valid; imem_rdata is captured in this cycle.
- imem_rdata  input  32  instruction word from memory.
- instr_valid  output  1  instr/pc/OpCode/funct are valid.
- instr_ready  input  1  consumer accepts the instruction; consumption occurs when instr_valid and instr_ready are both high.
- instr  output  32  current instruction word.
- OpCode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4.
- jump  input  1  current instruction is j; sampled only at consumption.
- Branch  input  1  current instruction is beq; sampled only at consumption.
- zero  input  1  ALU zero flag; sampled only at consumption.
- retired_cnt  output  32  count of consumed instructions.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = S_FETCH; pc = RESET_PC; instr = 0; retired_cnt = 0.
  - imem_req = 0 while rst_n is low; instr_valid = 0.
  - A reset during S_WAIT or S_ISSUE discards the in-flight fetch; any imem_ack arriving after reset is ignored until a new request is issued.
- State machine (registered state; all outputs registered):
  - S_FETCH: drive imem_req = 1 and imem_addr = pc; go to S_WAIT on the next edge. The first request appears in the first cycle after rst_n rises.
  - S_WAIT: hold imem_req = 1 and hold imem_addr stable.
    - imem_ack = 1: capture imem_rdata into instr, drop imem_req, go to S_ISSUE. instr_valid rises on the next cycle.
    - Ack may arrive any number of cycles after the request, including the cycle immediately following S_FETCH.
  - S_ISSUE: instr_valid = 1; instr, pc and OpCode/funct held stable until consumption.
    - On consumption: pc <= next_pc; retired_cnt += 1 (wraps at 2^32); instr_valid drops on the next edge; go to S_FETCH.
  - imem_ack outside S_WAIT: ignored, no state change.
- Next-PC rules, evaluated in the consumption cycle:
  - jump = 1: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else Branch and zero both 1: next_pc = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit wrap-around.
  - else: next_pc = pc_plus4.
  - jump has priority over Branch when both are high.
- Width and arithmetic:
  - pc_plus4 is combinational from pc.
  - PC addition wraps modulo 2^32 (pc = 32'hFFFF_FFFC yields 0).
  - pc[1:0] is always 00 given an aligned RESET_PC.
- Throughput: at most one instruction per 3 cycles with zero-wait memory (FETCH, WAIT, ISSUE). No prefetch and no buffering beyond one instruction.
- instr_ready low in S_ISSUE: stall indefinitely with all outputs stable and imem_req = 0.

Test Plan:
- Reset release with RESET_PC = 32'h3000 and memory acking 1 cycle after each request, instr_ready tied high:
  - imem_addr sequence 32'h3000, 32'h3004, 32'h3008.
  - retired_cnt = 3 after the third consumption.
- Fetch of instr 32'h0800_0C10 with jump = 1 at pc = 32'h3004 -> next imem_addr = 32'h0000_3040.
- beq 32'h1000_FFFE at pc = 32'h3010:
  - Branch = 1, zero = 1 -> next addr 32'h300C.
  - Branch = 1, zero = 0 -> next addr 32'h3014.
- Memory ack delayed 5 cycles:
  - imem_req and imem_addr held constant for all 5 cycles.
  - instr_valid stays 0 until the cycle after the ack.
  - A spurious ack injected during S_ISSUE causes no change.
- instr_ready held low for 4 cycles in S_ISSUE:
  - instr, pc and instr_valid stable; no new imem_req.
  - Release -> exactly one retirement.
- rst_n pulsed low during S_WAIT at pc = 32'h3020:
  - pc returns to 32'h3000 immediately and instr_valid = 0.
  - A late ack is ignored; the first post-reset request is addr 32'h3000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Single-entry instruction fetch stage: fetches the word at pc over a req/ack handshake,
// holds it for the decoder until consumed, then steps pc by sequential/jump/branch rules.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [5:0]        OpCode,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              jump,
   input  logic              Branch,
   input  logic              zero,
   output logic [31:0]       retired_cnt
);

   typedef enum logic [1:0] {
      StFetch = 2'b00,
      StWait  = 2'b01,
      StIssue = 2'b10
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_req;
   logic              w_req_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic [31:0]       r_instr;
   logic [31:0]       w_instr_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [31:0]       r_cnt;
   logic [31:0]       w_cnt_nxt;
   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_br_off;
   logic [ADDR_W-1:0] w_next_pc;

   assign w_pc_plus4 = r_pc + ADDR_W'(4);

   // State and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StFetch;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= RESET_PC;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_valid <= w_valid_nxt;
         r_instr <= w_instr_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A fetch only leaves StFetch once the request is actually on the bus; right after reset
   // that costs one extra cycle so imem_req stays low throughout reset.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StFetch: if (r_req)       w_state_nxt = StWait;
         StWait:  if (imem_ack)    w_state_nxt = StIssue;
         StIssue: if (instr_ready) w_state_nxt = StFetch;
         default:                  w_state_nxt = StFetch;
      endcase
   end

   always_comb begin
      w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
      if (jump) begin
         w_next_pc = {w_pc_plus4[ADDR_W-1:ADDR_W-4], r_instr[25:0], 2'b00};
      end else if (Branch && zero) begin
         w_next_pc = w_pc_plus4 + w_br_off;
      end else begin
         w_next_pc = w_pc_plus4;
      end
   end

   always_comb begin
      w_req_nxt   = r_req;
      w_valid_nxt = r_valid;
      w_instr_nxt = r_instr;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StFetch: w_req_nxt = 1'b1;
         StWait: begin
            if (imem_ack) begin
               w_req_nxt   = 1'b0;
               w_valid_nxt = 1'b1;
               w_instr_nxt = imem_rdata;
            end
         end
         StIssue: begin
            // Request is raised together with the new pc so the next StFetch drives it.
            if (instr_ready) begin
               w_req_nxt   = 1'b1;
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_next_pc;
               w_cnt_nxt   = r_cnt + 32'd1;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign OpCode      = r_instr[31:26];
   assign funct       = r_instr[5:0];
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign retired_cnt = r_cnt;

   a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n) r_pc[1:0] == 2'b00);
   a_req_xor_valid: assert property (@(posedge clk) disable iff (!rst_n) !(r_req && r_valid));

endmodule
